button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Upstream conditioning stage for the button-driven 7-segment letter/digit selector logic.
- Synchronises N raw mechanical button inputs (BTN[1:0] plus extra button on a GPIO pin) and debounces each one independently.
- Delivers clean stable levels, plus one-cycle press and release pulses.
- The selector consumes the levels; later counters and FSMs consume the pulses.

Parameters:
- N_BUTTONS, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a change; 1 ms at 50 MHz; minimum 2.
- ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed; inverted before synchronisation.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_raw  input  N_BUTTONS  raw, asynchronous, bouncing button inputs
- btn_level  output  N_BUTTONS  debounced level, 1 = pressed (after polarity correction)
- btn_press  output  N_BUTTONS  one-clk pulse when a channel's debounced level rises
- btn_release  output  N_BUTTONS  one-clk pulse when a channel's debounced level falls

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-high.
- Reset asserted: all outputs 0, synchronisers 0, every channel in RELEASED with counter 0.
- Input path: optional inversion (ACTIVE_LOW), then a 2-flop synchroniser per bit. Synchroniser output is "s".
- Per-channel FSM, 4 states:
  - RELEASED: level 0. s=1 -> CHECK_PRESS, counter cleared to 0.
  - CHECK_PRESS: level 0.
    - s=0 -> RELEASED; glitch rejected, no pulse.
    - s=1 -> counter increments.
    - Counter reaching DEBOUNCE_CYCLES-1 with s=1 -> PRESSED; btn_press=1 for exactly that transition cycle.
  - PRESSED: level 1. s=0 -> CHECK_RELEASE, counter cleared.
  - CHECK_RELEASE: level 1.
    - s=1 -> PRESSED; no pulse.
    - Counter reaching DEBOUNCE_CYCLES-1 with s=0 -> RELEASED; btn_release=1 for one cycle.
- Latency: a clean step on btn_raw sampled at edge k makes btn_level change and the pulse appear registered at edge k+2+DEBOUNCE_CYCLES. Outputs are registered; there is no combinational path from btn_raw.
- Counter width: $clog2(DEBOUNCE_CYCLES). It never wraps: it stops at the terminal value and the transition happens there.
- btn_press and btn_release:
  - Never both high on the same channel in the same cycle.
  - A pulse is never longer than 1 cycle.
  - Pulses are separated by at least DEBOUNCE_CYCLES+1 cycles.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- Button held through reset release: after deassertion the channel debounces normally. btn_press fires 2+DEBOUNCE_CYCLES cycles later, because pressed-at-reset is treated as a new press.
- Reset asserted mid-debounce: the state is discarded immediately and asynchronously. No pulse is emitted for the interrupted transition.
- A bounce in the last count cycle (s flips at counter = DEBOUNCE_CYCLES-1) aborts the transition. The counter restarts from the next qualifying cycle.

Decomposition:
- Shared package button_pkg holds:
  - enum debounce_state_t {RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE}, 2-bit encoding.
  - Default constant DEBOUNCE_CYCLES_DEFAULT = 50000.
- One sub-module, button_debounce_channel: 1-bit synchroniser, counter, FSM and pulse generation.
- button_debouncer holds the polarity inversion and a generate loop of N_BUTTONS channels.

Test Plan (DEBOUNCE_CYCLES=4, N_BUTTONS=3, ACTIVE_LOW=0):
- Clean press: btn_raw 000->001 at edge 10 -> btn_level[0]=1 and btn_press=001 at edge 16; btn_press=000 at edge 17; btn_level[1] and btn_level[2] stay 0.
- Glitch rejection: btn_raw[1] high for 3 cycles then low -> btn_level and btn_press stay 000 throughout.
- Release with bounce: btn_level[0]=1, then raw goes 1->0->1->0 with 1-cycle gaps, then holds 0 -> exactly one btn_release[0] pulse, 6 cycles after the final 1->0; no spurious btn_press.
- Simultaneous: btn_raw 000->111 at one edge -> btn_press=111 in the same single cycle 6 edges later; btn_level=111.
- Reset mid-operation: assert reset 3 cycles into CHECK_PRESS with raw still 1 -> outputs 000 immediately, no pulse during reset. Deassert -> btn_press fires 6 edges after deassertion.
- ACTIVE_LOW=1: btn_raw idle 111, drive bit 2 to 0 -> btn_level=100 and btn_press=100 after 6 edges.

Source files
------------

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared types and constants for the button debouncer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Per-channel debounce state. Bit 1 doubles as "debounced level is high".
    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } debounce_state_t;

    // 1 ms at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_channel
//  Description : One button channel: 2-flop synchroniser, stability counter,
//                4-state debounce FSM and registered press/release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync_meta;
    logic               r_sync;
    debounce_state_t    r_state;
    debounce_state_t    w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_level;
    logic               w_level_nxt;
    logic               r_press;
    logic               w_press_nxt;
    logic               r_release;
    logic               w_release_nxt;

    // Two-flop synchroniser bringing the asynchronous button into clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= i_raw;
            r_sync      <= r_sync_meta;
        end
    end

    // State, counter and registered outputs; reset discards any debounce in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Next-state logic: a change is accepted only after the counter reaches its
    // terminal value with the input still disagreeing; any agreeing sample aborts.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        case (r_state)
            RELEASED: begin
                if (r_sync) begin
                    w_state_nxt = CHECK_PRESS;
                    w_cnt_nxt   = '0;
                end
            end

            CHECK_PRESS: begin
                if (!r_sync) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end

            PRESSED: begin
                if (!r_sync) begin
                    w_state_nxt = CHECK_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end

            CHECK_RELEASE: begin
                if (r_sync) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt   = RELEASED;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : button_debounce_channel
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Polarity correction plus N independent debounce channels
//                delivering clean levels and one-cycle press/release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release
);

    logic [N_BUTTONS-1:0] w_btn_norm;

    // Normalise so that 1 always means "pressed" before synchronisation.
    assign w_btn_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_channel
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clk       (clk),
            .rst       (reset),
            .i_raw     (w_btn_norm[gi]),
            .o_level   (btn_level[gi]),
            .o_press   (btn_press[gi]),
            .o_release (btn_release[gi])
        );
    end

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench: directed scenarios plus random toggling
//                against a run-length reference model, two DUT polarities.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] raw_a, raw_b;
    logic [2:0] level_a, press_a, release_a;
    logic [2:0] level_b, press_b, release_b;

    int tests = 0;
    int fails = 0;

    // Reference model: synchroniser as a 2-deep delay, then a count of
    // consecutive samples disagreeing with the accepted level; DB+1 of them
    // in a row flip the level and emit one pulse.
    logic [2:0] m_d1  [2];
    logic [2:0] m_d2  [2];
    logic [2:0] m_lev [2];
    logic [2:0] m_prs [2];
    logic [2:0] m_rls [2];
    int         m_run [2][3];

    logic [2:0] seen_press, seen_rel;
    int         rel0_count;

    button_debouncer #(.N_BUTTONS(3), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .btn_raw(raw_a),
        .btn_level(level_a), .btn_press(press_a), .btn_release(release_a)
    );

    button_debouncer #(.N_BUTTONS(3), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .reset(reset), .btn_raw(raw_b),
        .btn_level(level_b), .btn_press(press_b), .btn_release(release_b)
    );

    always #5 clk = ~clk;

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_d1[i] = '0; m_d2[i] = '0; m_lev[i] = '0; m_prs[i] = '0; m_rls[i] = '0;
            for (int c = 0; c < 3; c++) m_run[i][c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [2:0] norm [2];
        norm[0] = raw_a;
        norm[1] = ~raw_b;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) begin
                m_prs[i][c] = 1'b0;
                m_rls[i][c] = 1'b0;
                if (m_d2[i][c] != m_lev[i][c]) begin
                    m_run[i][c]++;
                    if (m_run[i][c] == DB + 1) begin
                        m_lev[i][c] = ~m_lev[i][c];
                        if (m_lev[i][c]) m_prs[i][c] = 1'b1;
                        else             m_rls[i][c] = 1'b1;
                        m_run[i][c] = 0;
                    end
                end else begin
                    m_run[i][c] = 0;
                end
            end
            m_d2[i] = m_d1[i];
            m_d1[i] = norm[i];
        end
    endtask

    // One clock: advance model at the edge, compare every output 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check3("level_a",   level_a,   m_lev[0]);
        check3("press_a",   press_a,   m_prs[0]);
        check3("release_a", release_a, m_rls[0]);
        check3("level_b",   level_b,   m_lev[1]);
        check3("press_b",   press_b,   m_prs[1]);
        check3("release_b", release_b, m_rls[1]);
        check3("press_and_release_a", press_a & release_a, 3'b000);
        seen_press = seen_press | press_a;
        seen_rel   = seen_rel   | release_a;
        if (release_a[0]) rel0_count++;
    endtask

    initial begin
        reset      = 1'b1;
        raw_a      = 3'b000;
        raw_b      = 3'b111;
        seen_press = '0;
        seen_rel   = '0;
        rel0_count = 0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check3("reset_level_a", level_a, 3'b000);
        check3("reset_level_b", level_b, 3'b000);
        reset = 1'b0;
        repeat (4) tick();

        // Clean press on channel 0: pulse on the 7th edge after the change
        raw_a = 3'b001;
        repeat (6) tick();
        check3("clean_press_early", press_a, 3'b000);
        tick();
        check3("clean_press_pulse", press_a, 3'b001);
        check3("clean_press_level", level_a, 3'b001);
        tick();
        check3("clean_press_end", press_a, 3'b000);

        // Glitch on channel 1: three cycles high is not enough
        seen_press = '0;
        raw_a = 3'b011;
        repeat (3) tick();
        raw_a = 3'b001;
        repeat (8) tick();
        check3("glitch_no_press", seen_press, 3'b000);
        check3("glitch_level", level_a, 3'b001);

        // Release with bounce on channel 0
        seen_press = '0;
        rel0_count = 0;
        raw_a = 3'b000; tick();
        raw_a = 3'b001; tick();
        raw_a = 3'b000;
        repeat (6) tick();
        check3("bounce_release_early", release_a, 3'b000);
        tick();
        check3("bounce_release_pulse", release_a, 3'b001);
        repeat (6) tick();
        check_int("bounce_release_count", rel0_count, 1);
        check3("bounce_no_press", seen_press, 3'b000);

        // Simultaneous press on all channels
        raw_a = 3'b111;
        repeat (6) tick();
        check3("simul_early", press_a, 3'b000);
        tick();
        check3("simul_pulse", press_a, 3'b111);
        check3("simul_level", level_a, 3'b111);
        tick();
        check3("simul_end", press_a, 3'b000);
        raw_a = 3'b000;
        repeat (10) tick();

        // Reset mid-debounce with channel 2 already pressed
        raw_a = 3'b100;
        repeat (9) tick();
        check3("pre_reset_level", level_a, 3'b100);
        raw_a = 3'b101;
        repeat (5) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check3("async_reset_level", level_a, 3'b000);
        check3("async_reset_press", press_a, 3'b000);
        seen_press = '0;
        repeat (3) tick();
        check3("reset_no_pulse", seen_press, 3'b000);
        reset = 1'b0;
        repeat (6) tick();
        check3("post_reset_early", press_a, 3'b000);
        tick();
        check3("post_reset_press", press_a, 3'b101);
        raw_a = 3'b000;
        repeat (10) tick();

        // Active-low instance: drive bit 2 low
        raw_b = 3'b011;
        repeat (6) tick();
        check3("al_early", press_b, 3'b000);
        tick();
        check3("al_press", press_b, 3'b100);
        check3("al_level", level_b, 3'b100);
        raw_b = 3'b111;
        repeat (10) tick();

        // Random toggling on both instances against the model
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(7, 0) == 0) raw_a[b] = ~raw_a[b];
                if ($urandom_range(7, 0) == 0) raw_b[b] = ~raw_b[b];
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_button_debouncer
`default_nettype wire
